cl_cfg_reg_slv: RTL

//  Downstream consumer of one OCL cfg-bus slot (256B window). It turns single-cycle wr/rd

---
 rtl/cl_cfg_reg_pkg.sv | 18 +
 rtl/cl_cfg_reg_slv_if.sv | 16 +
 rtl/cl_cfg_ts_cnt.sv | 44 ++++
 rtl/cl_cfg_reg_slv.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cl_cfg_reg_pkg.sv
// Shared definitions for the cfg-bus register slave: register offsets,
// FSM state encoding and the read value returned for unmapped offsets.
package cl_cfg_reg_pkg;

    localparam logic [7:0] REG_ID       = 8'h00;
    localparam logic [7:0] REG_SCRATCH  = 8'h04;
    localparam logic [7:0] REG_CTRL     = 8'h08;
    localparam logic [7:0] REG_STATUS   = 8'h0C;
    localparam logic [7:0] REG_TS_LO    = 8'h10;
    localparam logic [7:0] REG_TS_HI    = 8'h14;
    localparam logic [7:0] REG_EVT      = 8'h18;
    localparam logic [7:0] REG_PROT_ERR = 8'h1C;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} cfg_slv_state_t;

endpackage

// File: rtl/cl_cfg_reg_slv_if.sv
// Cfg-bus slot: single-cycle wr/rd pulses in, single-cycle ack with rdata out.
interface cl_cfg_reg_slv_if;

    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;

    modport master (output cfg_addr, cfg_wdata, cfg_wr, cfg_rd,
                    input  cfg_ack, cfg_rdata);
    modport slave  (input  cfg_addr, cfg_wdata, cfg_wr, cfg_rd,
                    output cfg_ack, cfg_rdata);

endinterface

// File: rtl/cl_cfg_ts_cnt.sv
// Free-running CNT_W timestamp with synchronous clear and enable. wrap_o
// pulses in the cycle the all-ones value rolls over. snap_i (a TS_LO read)
// latches the upper word so a following TS_HI read is coherent with it.
module cl_cfg_ts_cnt #(
    parameter int CNT_W = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        snap_i,
    output logic [31:0] ts_lo_o,
    output logic [31:0] ts_hi_o,
    output logic        wrap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shadow_q;
    logic [63:0]      ts64;

    assign ts64    = 64'(cnt_q);
    assign ts_lo_o = ts64[31:0];
    assign ts_hi_o = shadow_q;
    assign wrap_o  = en_i && !clr_i && (&cnt_q);

    // Clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter and high-word snapshot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (snap_i) shadow_q <= ts64[63:32];
        end
    end

endmodule

// File: rtl/cl_cfg_reg_slv.sv
// Cfg-bus register slave: ID, scratch, control, status, timestamp, event
// counter and protocol-error counter behind a fixed-latency ack FSM.
// Build option: CL_CFG_REG_TIMESTAMP_EN builds the timestamp counter, its
// shadow register and STATUS[0]; without it TS_LO/TS_HI read 0.
module cl_cfg_reg_slv #(
    parameter logic [31:0] ID_VALUE = 32'hF00D_0001,
    parameter int          ACK_LAT  = 2,
    parameter int          CNT_W    = 48
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    cl_cfg_reg_slv_if.slave  cfg,
    input  logic             evt_in,
    output logic             cnt_en_o
);

    import cl_cfg_reg_pkg::*;

    if (CNT_W < 33 || CNT_W > 64 || ACK_LAT < 1 || ACK_LAT > 15) begin : g_bad_param
        $error("cl_cfg_reg_slv: CNT_W or ACK_LAT out of range");
    end

    localparam logic [3:0] LAT_LOAD = 4'(ACK_LAT - 1);

    cfg_slv_state_t state_q;
    logic [3:0]     lat_q;
    logic [7:0]     off_q;
    logic [31:0]    wdata_q;
    logic           is_wr_q;

    logic [31:0] scratch_q, evt_q, evt_d, perr_q;
    logic        en_q;
    logic [1:0]  status_q, status_d, status_set, status_w1c;

    logic        req, in_ack, acc_wr, acc_rd, prot_evt, ctrl_clr, evt_cnt;
    logic [31:0] rd_mux, ts_lo, ts_hi;
    logic        ts_wrap;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{cfg.cfg_addr[31:8], cfg.cfg_addr[1:0]};

    assign req      = cfg.cfg_wr | cfg.cfg_rd;
    assign in_ack   = (state_q == ACK);
    assign acc_wr   = in_ack &&  is_wr_q;
    assign acc_rd   = in_ack && !is_wr_q;
    // Simultaneous wr+rd while idle, or any pulse while busy, is a protocol error
    assign prot_evt = (state_q == IDLE) ? (cfg.cfg_wr & cfg.cfg_rd) : req;
    assign ctrl_clr = acc_wr && (off_q == REG_CTRL) && wdata_q[1];
    assign evt_cnt  = en_q && evt_in && !ctrl_clr;

    assign cfg.cfg_ack   = in_ack;
    assign cfg.cfg_rdata = acc_rd ? rd_mux : 32'd0;
    assign cnt_en_o      = en_q;

`ifdef CL_CFG_REG_TIMESTAMP_EN
    logic ts_snap;
    assign ts_snap = acc_rd && (off_q == REG_TS_LO);

    cl_cfg_ts_cnt #(.CNT_W(CNT_W)) u_ts (
        .clk     (clk),
        .rst_n   (sync_rst_n),
        .en_i    (en_q),
        .clr_i   (ctrl_clr),
        .snap_i  (ts_snap),
        .ts_lo_o (ts_lo),
        .ts_hi_o (ts_hi),
        .wrap_o  (ts_wrap)
    );
`else
    assign ts_lo   = 32'd0;
    assign ts_hi   = 32'd0;
    assign ts_wrap = 1'b0;
`endif

    // Sticky status: a set in the same cycle as its W1C wins
    always_comb begin
        status_set = {evt_cnt && (&evt_q[31:1]), ts_wrap};
        status_w1c = (acc_wr && off_q == REG_STATUS) ? wdata_q[1:0] : 2'b00;
        status_d   = (status_q & ~status_w1c) | status_set;
    end

    // Saturating event counter; clear wins over a same-cycle event
    always_comb begin
        evt_d = evt_q;
        if (ctrl_clr)                    evt_d = 32'd0;
        else if (evt_cnt && evt_q != '1) evt_d = evt_q + 32'd1;
    end

    // Read data mux, indexed by the captured word offset
    always_comb begin
        rd_mux = DEADBEEF;
        case (off_q)
            REG_ID:       rd_mux = ID_VALUE;
            REG_SCRATCH:  rd_mux = scratch_q;
            REG_CTRL:     rd_mux = {31'd0, en_q};
            REG_STATUS:   rd_mux = {30'd0, status_q};
            REG_TS_LO:    rd_mux = ts_lo;
            REG_TS_HI:    rd_mux = ts_hi;
            REG_EVT:      rd_mux = evt_q;
            REG_PROT_ERR: rd_mux = perr_q;
            default:      rd_mux = DEADBEEF;
        endcase
    end

    // Access FSM: capture request, count down latency, one ack cycle
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= IDLE;
            lat_q   <= 4'd0;
            off_q   <= 8'd0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    off_q   <= {cfg.cfg_addr[7:2], 2'b00};
                    wdata_q <= cfg.cfg_wdata;
                    is_wr_q <= cfg.cfg_wr;
                    lat_q   <= LAT_LOAD;
                    state_q <= (ACK_LAT == 1) ? ACK : WAIT;
                end
                WAIT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q <= 4'd1) state_q <= ACK;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register file updates, applied at the end of the ack cycle
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            scratch_q <= 32'd0;
            en_q      <= 1'b0;
            status_q  <= 2'b00;
            evt_q     <= 32'd0;
            perr_q    <= 32'd0;
        end else begin
            if (acc_wr && off_q == REG_SCRATCH) scratch_q <= wdata_q;
            if (acc_wr && off_q == REG_CTRL)    en_q      <= wdata_q[0];
            status_q <= status_d;
            evt_q    <= evt_d;
            if (prot_evt && perr_q != '1) perr_q <= perr_q + 32'd1;
        end
    end

endmodule
